// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the front-end stages.
package pipe_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_VALID
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time and presents the fetched instruction (or a NOP bubble) to IF/ID.
module fetch_stage
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_pcF,
   output logic [31:0] o_instF,
   output logic [31:0] o_pc_fourF,
   output logic        o_validF
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  inst_q, inst_d;
   logic         kill_q, kill_d;
   logic [31:0]  redirect_target;

   assign redirect_target = i_redirect_pc & 32'hFFFF_FFFC;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         kill_q  <= kill_d;
      end
   end

   // kill marks an in-flight request whose response must be dropped because a
   // redirect happened after it was accepted.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      kill_d  = kill_q;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            if (i_imem_ready) begin
               state_d = S_WAIT;
               kill_d  = i_redirect;
            end
         end
         S_WAIT: begin
            if (i_imem_rvalid) begin
               kill_d = 1'b0;
               if (kill_q || i_redirect) begin
                  state_d = S_REQ;
               end else begin
                  inst_d  = i_imem_rdata;
                  state_d = S_VALID;
               end
            end else if (i_redirect) begin
               kill_d = 1'b1;
            end
         end
         S_VALID: begin
            if (i_redirect) begin
               inst_d  = NOP_INST;
               state_d = S_REQ;
            end else if (!i_stall) begin
               pc_d    = pc_q + 32'd4;
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (i_redirect) begin
         pc_d = redirect_target;
      end
   end

   assign o_imem_req  = (state_q == S_REQ);
   assign o_imem_addr = pc_q;
   assign o_pcF       = pc_q;
   assign o_pc_fourF  = pc_q + 32'd4;
   assign o_validF    = (state_q == S_VALID);
   assign o_instF     = o_validF ? inst_q : NOP_INST;

endmodule
